// File: rtl/puzzle_pkg.sv
// Shared types and constants for the sliding-tile board controller.
package puzzle_pkg;

   typedef enum logic [1:0] {StIdle, StShuffle, StPlay, StWin} state_e;

   typedef enum logic [1:0] {
      DirUp    = 2'd0,
      DirDown  = 2'd1,
      DirLeft  = 2'd2,
      DirRight = 2'd3
   } dir_e;

   // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
   localparam logic [15:0] LfsrTaps = 16'hB400;

   // Solved order for a side x side board, packed cell k at [k*tw +: tw]; sized for side <= 4
   function automatic logic [63:0] solved_board(input int unsigned side);
      int unsigned cells;
      int unsigned tw;
      logic [63:0] b;
      cells = side * side;
      tw    = $clog2(cells);
      b     = '0;
      for (int unsigned k = 0; k < cells - 1; k++) begin
         b = b | (64'(k + 1) << (k * tw));
      end
      return b;
   endfunction

endpackage

// File: rtl/btn_pulse.sv
// Two-flop synchroniser plus rising-edge detector: a level button becomes a one-cycle pulse.
module btn_pulse #(
   parameter int unsigned WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] btn,
   output logic [WIDTH-1:0] pulse
);

   logic [WIDTH-1:0] sync1_q, sync2_q, prev_q;

   // Synchronise the raw level and remember the previous synchronised value
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_q <= '0;
         sync2_q <= '0;
         prev_q  <= '0;
      end else begin
         sync1_q <= btn;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   assign pulse = sync2_q & ~prev_q;

endmodule

// File: rtl/puzzle_board_ctrl.sv
// SIDE x SIDE sliding-tile game engine: input pulses, shuffle LFSR, board state and win flag.
// Optional feature macro: MOVE_COUNT_EN (player move counter; move_cnt tied to 0 when undefined).
module puzzle_board_ctrl
   import puzzle_pkg::*;
#(
   parameter int unsigned SIDE       = 3,
   parameter int unsigned SHUF_MOVES = 64,
   parameter int unsigned CNT_W      = 10,
   parameter logic [15:0] LFSR_SEED  = 16'hACE1,
   localparam int unsigned CELLS     = SIDE * SIDE,
   localparam int unsigned TW        = $clog2(CELLS)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [3:0]          btn_dir,
   input  logic                btn_shuf,
   input  logic                btn_start,
   output logic [CELLS*TW-1:0] board,
   output logic [TW-1:0]       blank_pos,
   output logic [CNT_W-1:0]    move_cnt,
   output logic                busy,
   output logic                solved
);

   localparam logic [63:0] SolvedAll = solved_board(SIDE);

   logic [5:0]    pulse;
   logic          up_p, down_p, left_p, right_p, shuf_p, start_p;
   logic [15:0]   lfsr_q;
   state_e        state_q;
   logic [9:0]    shuf_cnt_q;
   logic [TW-1:0] cell_q [CELLS];
   logic [TW-1:0] blank_q;
   logic          moved_q;
   logic          dir_vld;
   dir_e          dir_sel;
   dir_e          mv_dir;
   logic          nb_legal;
   logic [TW-1:0] nb_idx;
   logic          win_now;
   logic          do_swap;
   logic          player_move;
   logic          shuf_done;

   btn_pulse #(
      .WIDTH(6)
   ) u_btn_pulse (
      .clk  (clk),
      .rst  (rst),
      .btn  ({btn_start, btn_shuf, btn_dir}),
      .pulse(pulse)
   );

   assign {start_p, shuf_p, up_p, down_p, left_p, right_p} = pulse;

   // Free-running shuffle randomness, advances in every state
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) lfsr_q <= LFSR_SEED;
      else      lfsr_q <= {lfsr_q[14:0], ^(lfsr_q & LfsrTaps)};
   end

   // Player direction with fixed priority up > down > left > right
   always_comb begin
      dir_vld = 1'b1;
      dir_sel = DirUp;
      if (up_p)         dir_sel = DirUp;
      else if (down_p)  dir_sel = DirDown;
      else if (left_p)  dir_sel = DirLeft;
      else if (right_p) dir_sel = DirRight;
      else              dir_vld = 1'b0;
   end

   // Neighbour of the blank in the chosen direction and whether it lies on the board
   always_comb begin
      int unsigned bpos, row, col, npos;
      mv_dir   = (state_q == StShuffle) ? dir_e'(lfsr_q[1:0]) : dir_sel;
      bpos     = 32'(blank_q);
      row      = bpos / SIDE;
      col      = bpos % SIDE;
      npos     = bpos;
      nb_legal = 1'b0;
      case (mv_dir)
         DirUp:    if (row != 0)        begin nb_legal = 1'b1; npos = bpos - SIDE; end
         DirDown:  if (row != SIDE - 1) begin nb_legal = 1'b1; npos = bpos + SIDE; end
         DirLeft:  if (col != 0)        begin nb_legal = 1'b1; npos = bpos - 1;    end
         DirRight: if (col != SIDE - 1) begin nb_legal = 1'b1; npos = bpos + 1;    end
         default:  ;
      endcase
      nb_idx = TW'(npos);
   end

   // Flatten the board register array onto the output bus
   always_comb begin
      board = '0;
      for (int unsigned k = 0; k < CELLS; k++) begin
         board[k*TW +: TW] = cell_q[k];
      end
   end

   // Decide this cycle's swap; a win only counts right after a player move
   always_comb begin
      win_now     = moved_q && (board == SolvedAll[CELLS*TW-1:0]);
      do_swap     = 1'b0;
      player_move = 1'b0;
      shuf_done   = (state_q == StShuffle) && (shuf_cnt_q == 10'(SHUF_MOVES - 1));
      case (state_q)
         StShuffle: do_swap = nb_legal;
         StPlay: begin
            if (!start_p && !shuf_p && !win_now && dir_vld && nb_legal) begin
               do_swap     = 1'b1;
               player_move = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // Game FSM with board registers and registered status outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= StIdle;
         shuf_cnt_q <= '0;
         blank_q    <= TW'(CELLS - 1);
         moved_q    <= 1'b0;
         busy       <= 1'b0;
         solved     <= 1'b0;
         for (int unsigned k = 0; k < CELLS; k++) cell_q[k] <= SolvedAll[k*TW +: TW];
      end else begin
         moved_q <= player_move;
         if (do_swap) begin
            cell_q[blank_q] <= cell_q[nb_idx];
            cell_q[nb_idx]  <= '0;
            blank_q         <= nb_idx;
         end
         case (state_q)
            StIdle: begin
               if (shuf_p) begin
                  state_q    <= StShuffle;
                  shuf_cnt_q <= '0;
                  busy       <= 1'b1;
               end
            end
            StShuffle: begin
               if (shuf_done) begin
                  state_q <= StPlay;
                  busy    <= 1'b0;
               end else begin
                  shuf_cnt_q <= shuf_cnt_q + 10'd1;
               end
            end
            StPlay, StWin: begin
               if (start_p) begin
                  // Later assignments override any swap scheduled above
                  state_q <= StIdle;
                  solved  <= 1'b0;
                  blank_q <= TW'(CELLS - 1);
                  for (int unsigned k = 0; k < CELLS; k++) cell_q[k] <= SolvedAll[k*TW +: TW];
               end else if (shuf_p) begin
                  state_q    <= StShuffle;
                  shuf_cnt_q <= '0;
                  busy       <= 1'b1;
                  solved     <= 1'b0;
               end else if (state_q == StPlay && win_now) begin
                  state_q <= StWin;
                  solved  <= 1'b1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign blank_pos = blank_q;

`ifdef MOVE_COUNT_EN
   logic [CNT_W-1:0] cnt_q;

   // Player move counter: cleared when a shuffle completes, saturates at all-ones
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                            cnt_q <= '0;
      else if (shuf_done)                  cnt_q <= '0;
      else if (player_move && cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
   end

   assign move_cnt = cnt_q;
`else
   assign move_cnt = '0;
`endif

endmodule
